uart_modem_ctrl: RTL and testbench
==================================

Name: uart_modem_ctrl

Overview:
- DUT-side modem control/status block of the APB UART: the responder end of the modem handshake lines.
- Synchronises the external active-low modem inputs (nCTS, nDSR, nDCD, nRI) and presents them as a 16550-style Modem Status Register (MSR) with delta bits.
- Drives the active-low modem outputs (nRTS, nDTR, OUT1, OUT2) from a Modem Control Register (MCR), supports loopback, and raises the modem-status interrupt request.
- Sits between the APB register decoder and the chip-level modem pins.

Parameters:
SYNC_STAGES, 2, number of flip-flops in each input synchroniser (legal range 2..4)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  asynchronous, active-high reset
nCTS  input  1  clear-to-send pin, active low, asynchronous to clk
nDSR  input  1  data-set-ready pin, active low, asynchronous
nDCD  input  1  data-carrier-detect pin, active low, asynchronous
nRI  input  1  ring-indicator pin, active low, asynchronous
mcr_we  input  1  MCR write strobe, one clk cycle
mcr_wdata  input  5  MCR write data: [0]DTR [1]RTS [2]OUT1 [3]OUT2 [4]LOOP
msr_rd  input  1  MSR read strobe, one clk cycle
ier_msi  input  1  modem-status interrupt enable (IER bit 3)
mcr  output  5  current MCR contents
msr  output  8  [0]DCTS [1]DDSR [2]TERI [3]DDCD [4]CTS [5]DSR [6]RI [7]DCD
nRTS  output  1  request-to-send pin, active low
nDTR  output  1  data-terminal-ready pin, active low
OUT1  output  1  user output 1 pin, active low
OUT2  output  1  user output 2 pin, active low
modem_int  output  1  modem-status interrupt request, level

Behaviour:
- Reset (async, rst=1):
  - mcr=0 and msr=0.
  - All synchroniser stages and previous-value registers load 1 (pins inactive), so no delta bit fires when reset releases with pins idle.
  - nRTS, nDTR, OUT1 and OUT2 are 1; modem_int is 0.
- MCR:
  - mcr_we loads mcr_wdata on the next edge.
  - Pin outputs are registered from mcr with zero extra latency: nDTR=~mcr[0], nRTS=~mcr[1], OUT1=~mcr[2], OUT2=~mcr[3].
  - When mcr[4]=1 (loopback), all four pin outputs are forced to 1.
- Status sources:
  - Normal mode: each cur_x is the inverted synchroniser output. Example: cur_cts = ~sync(nCTS).
  - Loopback mode: the sources are internal and unsynchronised: cur_cts=mcr[1], cur_dsr=mcr[0], cur_ri=mcr[2], cur_dcd=mcr[3].
  - External pins are ignored in loopback.
- Status bits: msr[7:4] = {cur_dcd, cur_ri, cur_dsr, cur_cts}.
  - Latency from a pin edge to the msr status bit is SYNC_STAGES cycles.
  - In loopback, the status bit follows mcr one cycle after the write.
- Edge detection:
  - One prev register per source, updated every cycle from cur.
  - DCTS/DDSR/DDCD set when cur!=prev; they rise in the same cycle the status bit changes.
  - TERI sets only when prev_ri=1 and cur_ri=0 (RI trailing edge, i.e. nRI 0->1).
  - A loopback entry or exit that changes a cur value sets the corresponding delta bit.
- Clear-on-read:
  - msr is read combinationally by the decoder.
  - On the edge where msr_rd=1, msr[3:0] clear.
  - If a new delta event occurs in the same cycle as msr_rd, that bit stays 1 (set wins); the other bits clear.
  - msr_rd does not affect msr[7:4].
- Interrupt: modem_int = ier_msi & |msr[3:0]. Combinational from registers, no added latency.
- mcr_we and msr_rd in the same cycle are independent; both take effect.
- rst mid-operation: immediate return to reset values; pending deltas are lost.

Test Plan:
- Reset then idle with pins at 1 for 20 cycles -> msr=0x00, mcr=0x00, all pin outputs 1, modem_int=0.
- Drive nCTS 1->0 with ier_msi=1 -> after 2 cycles msr=0x11 and modem_int=1. Pulse msr_rd -> msr=0x10, modem_int=0.
- nRI 1->0 -> msr=0x40 (RI rises, no TERI). Then nRI 0->1 -> msr=0x04. A second nRI 1->0 gives no TERI.
- Write mcr=0x1F -> nRTS/nDTR/OUT1/OUT2 all stay 1. Next cycle msr=0xFF (status 0xF0 plus four deltas). Toggle external pins -> msr[7:4] unchanged.
- Pulse msr_rd in the same cycle the synchronised nDCD falls -> DDCD remains set (msr[3]=1); other deltas clear.
- Write mcr=0x03 -> nDTR=0, nRTS=0. Assert rst mid-frame with nDSR=0 -> mcr=0x00, pins 1, msr=0x00. After release, msr=0x22 within 2 cycles.

Source files
------------

// File: rtl/uart_modem_ctrl.sv
// uart_modem_ctrl: 16550-style modem control/status block with input synchronisers, delta detection and loopback.
module uart_modem_ctrl #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       nCTS,
   input  logic       nDSR,
   input  logic       nDCD,
   input  logic       nRI,
   input  logic       mcr_we,
   input  logic [4:0] mcr_wdata,
   input  logic       msr_rd,
   input  logic       ier_msi,
   output logic [4:0] mcr,
   output logic [7:0] msr,
   output logic       nRTS,
   output logic       nDTR,
   output logic       OUT1,
   output logic       OUT2,
   output logic       modem_int
);
   // Pin-polarity status register doubles as the last synchroniser stage, so the
   // front chain holds SYNC_STAGES-1 flops and the status bit lands SYNC_STAGES cycles after a pin edge.
   logic [SYNC_STAGES-2:0][3:0] sync;
   logic [3:0] stat_n, stat, cur, ev, delta, pins;
   logic [4:0] mcr_nxt;
   assign stat = ~stat_n;
   assign cur = mcr[4] ? {mcr[3], mcr[2], mcr[0], mcr[1]} : ~sync[SYNC_STAGES-2];
   assign ev = {cur[3] ^ stat[3], stat[2] & ~cur[2], cur[1] ^ stat[1], cur[0] ^ stat[0]};
   assign mcr_nxt = mcr_we ? mcr_wdata : mcr;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '1;
         stat_n <= '1;
         delta <= '0;
         mcr <= '0;
         pins <= '1;
      end else begin
         sync[0] <= {nDCD, nRI, nDSR, nCTS};
         for (int i = 1; i < SYNC_STAGES - 1; i++) sync[i] <= sync[i-1];
         stat_n <= ~cur;
         delta <= (msr_rd ? 4'h0 : delta) | ev;
         mcr <= mcr_nxt;
         pins <= mcr_nxt[4] ? 4'hF : ~mcr_nxt[3:0];
      end
   end
   assign {OUT2, OUT1, nRTS, nDTR} = pins;
   assign msr = {stat, delta};
   assign modem_int = ier_msi & |delta;
endmodule

// File: tb/tb_uart_modem_ctrl.sv
// tb_uart_modem_ctrl: directed and random stimulus against a queue-based reference model with a decoupled monitor.
module tb_uart_modem_ctrl;
   localparam int SS = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic nCTS = 1'b1, nDSR = 1'b1, nDCD = 1'b1, nRI = 1'b1;
   logic mcr_we = 1'b0, msr_rd = 1'b0, ier_msi = 1'b0;
   logic [4:0] mcr_wdata = '0;
   logic [4:0] mcr;
   logic [7:0] msr;
   logic nRTS, nDTR, OUT1, OUT2, modem_int;

   uart_modem_ctrl #(.SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .nCTS(nCTS), .nDSR(nDSR), .nDCD(nDCD), .nRI(nRI),
      .mcr_we(mcr_we), .mcr_wdata(mcr_wdata), .msr_rd(msr_rd), .ier_msi(ier_msi),
      .mcr(mcr), .msr(msr), .nRTS(nRTS), .nDTR(nDTR), .OUT1(OUT1), .OUT2(OUT2),
      .modem_int(modem_int)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] mcr;
      logic [7:0] msr;
      logic [3:0] pins;
      logic       irq;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   // Reference state: status/delta bits are in msr order {dcd,ri,dsr,cts}; pin samples are {nDCD,nRI,nDSR,nCTS}.
   logic [4:0] m_mcr;
   logic [3:0] m_stat, m_delta;
   logic [3:0] hist[$];
   logic [3:0] pins_v = 4'hF;

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_step(input logic r, input logic [3:0] p, input logic we,
                             input logic [4:0] wd, input logic rd, input logic ier);
      logic [3:0] nxt, chg;
      exp_t e;
      if (r) begin
         m_mcr = '0;
         m_stat = '0;
         m_delta = '0;
         hist = {};
         repeat (SS - 1) hist.push_back(4'hF);
      end else begin
         nxt = m_mcr[4] ? {m_mcr[3], m_mcr[2], m_mcr[0], m_mcr[1]} : ~hist[0];
         hist.push_back(p);
         void'(hist.pop_front());
         chg = nxt ^ m_stat;
         m_delta = (rd ? 4'h0 : m_delta) | {chg[3], m_stat[2] & ~nxt[2], chg[1], chg[0]};
         m_stat = nxt;
         if (we) m_mcr = wd;
      end
      e.mcr = m_mcr;
      e.msr = {m_stat, m_delta};
      e.pins = m_mcr[4] ? 4'hF : ~m_mcr[3:0];
      e.irq = ier & (m_delta != 4'h0);
      sb.push_back(e);
   endtask

   task automatic cyc(input logic [3:0] p, input logic we = 1'b0, input logic [4:0] wd = '0,
                      input logic rd = 1'b0, input logic ier = 1'b0, input logic r = 1'b0);
      @(negedge clk);
      rst = r;
      {nDCD, nRI, nDSR, nCTS} = p;
      mcr_we = we;
      mcr_wdata = wd;
      msr_rd = rd;
      ier_msi = ier;
      pins_v = p;
      model_step(r, p, we, wd, rd, ier);
   endtask

   task automatic peek();
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("scoreboard {mcr,msr,pins,irq}", {mcr, msr, OUT2, OUT1, nRTS, nDTR, modem_int}, e);
         end
      end
   end

   initial begin : stim
      repeat (3) cyc(4'hF, .r(1'b1));
      repeat (20) cyc(4'hF);
      peek();
      chk("idle msr", msr, 8'h00);
      chk("idle mcr", mcr, 5'h00);
      chk("idle pins", {OUT2, OUT1, nRTS, nDTR}, 4'hF);
      chk("idle irq", modem_int, 0);
      cyc(4'hE, .ier(1'b1));
      cyc(4'hE, .ier(1'b1));
      peek();
      chk("cts msr", msr, 8'h11);
      chk("cts irq", modem_int, 1);
      cyc(4'hE, .rd(1'b1), .ier(1'b1));
      peek();
      chk("cts read msr", msr, 8'h10);
      chk("cts read irq", modem_int, 0);
      cyc(4'hF, .ier(1'b1));
      cyc(4'hF, .ier(1'b1));
      cyc(4'hF, .rd(1'b1), .ier(1'b1));
      peek();
      chk("cts release cleared", msr, 8'h00);
      cyc(4'hB, .ier(1'b1));
      cyc(4'hB, .ier(1'b1));
      peek();
      chk("ri lead no teri", msr, 8'h40);
      cyc(4'hF, .ier(1'b1));
      cyc(4'hF, .ier(1'b1));
      peek();
      chk("ri trail teri", msr, 8'h04);
      cyc(4'hF, .rd(1'b1), .ier(1'b1));
      cyc(4'hB, .ier(1'b1));
      cyc(4'hB, .ier(1'b1));
      peek();
      chk("second ri lead no teri", msr, 8'h40);
      cyc(4'hF, .ier(1'b1));
      cyc(4'hF, .ier(1'b1));
      cyc(4'hF, .we(1'b1), .wd(5'h1F), .ier(1'b1));
      peek();
      chk("loop mcr", mcr, 5'h1F);
      chk("loop pins forced", {OUT2, OUT1, nRTS, nDTR}, 4'hF);
      cyc(4'hF, .ier(1'b1));
      peek();
      chk("loop msr", msr, 8'hFF);
      cyc(4'h0, .ier(1'b1));
      cyc(4'h5, .ier(1'b1));
      cyc(4'h0, .ier(1'b1));
      peek();
      chk("loop ignores pins", msr, 8'hFF);
      cyc(4'hF, .ier(1'b1));
      cyc(4'hF, .ier(1'b1));
      cyc(4'hF, .we(1'b1), .wd(5'h00), .ier(1'b1));
      cyc(4'hF, .ier(1'b1));
      cyc(4'hF, .rd(1'b1), .ier(1'b1));
      peek();
      chk("loop exit cleared", msr, 8'h00);
      cyc(4'hE, .ier(1'b1));
      cyc(4'hE, .ier(1'b1));
      cyc(4'h6, .ier(1'b1));
      cyc(4'h6, .rd(1'b1), .ier(1'b1));
      peek();
      chk("read vs ddcd set wins", msr, 8'h98);
      cyc(4'h6, .we(1'b1), .wd(5'h03), .ier(1'b1));
      peek();
      chk("mcr 03 pins", {OUT2, OUT1, nRTS, nDTR}, 4'hC);
      cyc(4'hD, .r(1'b1));
      #1;
      chk("async rst mcr", mcr, 5'h00);
      chk("async rst pins", {OUT2, OUT1, nRTS, nDTR}, 4'hF);
      chk("async rst msr", msr, 8'h00);
      cyc(4'hD, .r(1'b1));
      cyc(4'hD);
      cyc(4'hD);
      peek();
      chk("dsr after rst", msr, 8'h22);
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] p;
         p = ($urandom_range(0, 3) == 0) ? 4'($urandom) : pins_v;
         cyc(p, ($urandom_range(0, 7) == 0), 5'($urandom), ($urandom_range(0, 3) == 0),
             1'($urandom), ($urandom_range(0, 199) == 0));
      end
      repeat (3) @(negedge clk);
      chk("scoreboard drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
